modulo_varredura_matriz: RTL and testbench

MODULO_VARREDURA_MATRIZ -- requirements
Module: modulo_varredura_matriz

---
 rtl/modulo_varredura_matriz_pkg.sv | 19 +
 rtl/modulo_divisor_varredura.sv | 31 +++
 rtl/modulo_varredura_matriz.sv | 115 +++++++++++
 tb/tb_modulo_varredura_matriz.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_varredura_matriz_pkg.sv
// Shared constants for the matrix scan block: default geometry, FSM encoding
// and the row-drive decoder.
package modulo_varredura_matriz_pkg;

  localparam int unsigned NUM_COL_PADRAO = 5;
  localparam int unsigned NUM_LIN_PADRAO = 7;
  localparam int unsigned DIV_PADRAO     = 4;

  typedef enum logic {
    OCIOSO = 1'b0,
    VARRE  = 1'b1
  } estado_t;

  // Active-low one-hot drive for the selected row.
  function automatic logic [7:0] linha_ativa(input logic [2:0] lin);
    return ~(8'd1 << lin);
  endfunction

endpackage

// File: rtl/modulo_divisor_varredura.sv
// Dwell divider: counts 0..DIV-1 while enabled; terminal marks the last
// enabled cycle of a position, so the scan advances on that edge.
module modulo_divisor_varredura #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic habilita,
  input  logic limpa,
  output logic terminal
);

  localparam logic [7:0] ULTIMO = 8'(DIV - 1);

  logic [7:0] contagem;

  // Terminal only while enabled, so a pause holds back the advance.
  assign terminal = habilita && (contagem == ULTIMO);

  // Counter: clear has priority, wraps on terminal, frozen when disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      contagem <= 8'd0;
    end else if (limpa || terminal) begin
      contagem <= 8'd0;
    end else if (habilita) begin
      contagem <= contagem + 8'd1;
    end
  end

endmodule

// File: rtl/modulo_varredura_matriz.sv
// Row-major matrix scanner: walks (mdc, mdl) over NUM_COL x NUM_LIN positions,
// holding each for DIV cycles, with single-frame or continuous operation.
module modulo_varredura_matriz
  import modulo_varredura_matriz_pkg::*;
#(
  parameter int unsigned DIV     = DIV_PADRAO,
  parameter int unsigned NUM_COL = NUM_COL_PADRAO,
  parameter int unsigned NUM_LIN = NUM_LIN_PADRAO
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       continuo,
  input  logic       pausa,
  output logic [2:0] mdc,
  output logic [2:0] mdl,
  output logic       valido,
  output logic       ocupado,
  output logic       quadro_fim,
  output logic [7:0] linha_n
);

  localparam logic [2:0] ULT_COL = 3'(NUM_COL - 1);
  localparam logic [2:0] ULT_LIN = 3'(NUM_LIN - 1);

  estado_t    estado, estado_prox;
  logic [2:0] mdc_prox, mdl_prox;
  logic       valido_prox, ocupado_prox, fim_prox;
  logic [7:0] linha_prox;
  logic       habilita, limpa, terminal;

  // Divider runs only while scanning and unpaused; idle keeps it at zero so
  // each frame starts with a full dwell on (0,0).
  assign habilita = (estado == VARRE) && !pausa;
  assign limpa    = (estado == OCIOSO);

  modulo_divisor_varredura #(
    .DIV(DIV)
  ) u_divisor (
    .clk     (clk),
    .reset_n (reset_n),
    .habilita(habilita),
    .limpa   (limpa),
    .terminal(terminal)
  );

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    estado_prox  = estado;
    mdc_prox     = mdc;
    mdl_prox     = mdl;
    valido_prox  = 1'b0;
    ocupado_prox = ocupado;
    fim_prox     = 1'b0;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          estado_prox  = VARRE;
          mdc_prox     = 3'd0;
          mdl_prox     = 3'd0;
          valido_prox  = 1'b1;
          ocupado_prox = 1'b1;
        end
      end
      VARRE: begin
        // terminal already excludes paused cycles, so pause wins here.
        if (terminal) begin
          if (mdc == ULT_COL) begin
            mdc_prox = 3'd0;
            if (mdl == ULT_LIN) begin
              mdl_prox = 3'd0;
              fim_prox = 1'b1;
              if (continuo) begin
                valido_prox = 1'b1;
              end else begin
                estado_prox  = OCIOSO;
                ocupado_prox = 1'b0;
              end
            end else begin
              mdl_prox    = mdl + 3'd1;
              valido_prox = 1'b1;
            end
          end else begin
            mdc_prox    = mdc + 3'd1;
            valido_prox = 1'b1;
          end
        end
      end
      default: estado_prox = OCIOSO;
    endcase
    linha_prox = ocupado_prox ? linha_ativa(mdl_prox) : 8'hFF;
  end

  // Registered state and outputs; reset forces idle mid-scan as well.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= OCIOSO;
      mdc        <= 3'd0;
      mdl        <= 3'd0;
      valido     <= 1'b0;
      ocupado    <= 1'b0;
      quadro_fim <= 1'b0;
      linha_n    <= 8'hFF;
    end else begin
      estado     <= estado_prox;
      mdc        <= mdc_prox;
      mdl        <= mdl_prox;
      valido     <= valido_prox;
      ocupado    <= ocupado_prox;
      quadro_fim <= fim_prox;
      linha_n    <= linha_prox;
    end
  end

endmodule

// File: tb/tb_modulo_varredura_matriz.sv
// Directed bench for the matrix scanner: DIV=4 instance for frame, continuous,
// pause, reset and re-start cases; DIV=1 instance for the back-to-back strobe.
module tb_modulo_varredura_matriz;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic iniciar = 1'b0, continuo = 1'b0, pausa = 1'b0;
  logic [2:0] mdc, mdl;
  logic valido, ocupado, quadro_fim;
  logic [7:0] linha_n;

  logic iniciar1 = 1'b0;
  logic [2:0] mdc1, mdl1;
  logic valido1, ocupado1, quadro_fim1;
  logic [7:0] linha_n1;

  int n_testes = 0;
  int n_falhas = 0;
  int cyc = 0;
  int qf_cnt = 0;

  always #5 clk = ~clk;

  modulo_varredura_matriz #(.DIV(4), .NUM_COL(5), .NUM_LIN(7)) u_dut (
    .clk(clk), .reset_n(reset_n), .iniciar(iniciar), .continuo(continuo),
    .pausa(pausa), .mdc(mdc), .mdl(mdl), .valido(valido), .ocupado(ocupado),
    .quadro_fim(quadro_fim), .linha_n(linha_n)
  );

  modulo_varredura_matriz #(.DIV(1), .NUM_COL(5), .NUM_LIN(7)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .iniciar(iniciar1), .continuo(1'b0),
    .pausa(1'b0), .mdc(mdc1), .mdl(mdl1), .valido(valido1), .ocupado(ocupado1),
    .quadro_fim(quadro_fim1), .linha_n(linha_n1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_testes++;
    if (obs !== exp) begin
      n_falhas++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (quadro_fim) qf_cnt++;
  endtask

  task automatic run_to(input int alvo);
    while (cyc < alvo) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    iniciar = 1'b0; continuo = 1'b0; pausa = 1'b0; iniciar1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    qf_cnt = 0;
  endtask

  task automatic start4();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mdc"}, 32'(mdc), 32'd0);
    chk({tag, "_mdl"}, 32'(mdl), 32'd0);
    chk({tag, "_valido"}, 32'(valido), 32'd0);
    chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
    chk({tag, "_qfim"}, 32'(quadro_fim), 32'd0);
    chk({tag, "_linha"}, 32'(linha_n), 32'hFF);
  endtask

  initial begin
    // Single frame, DIV=4.
    do_reset();
    chk_idle("rst");
    run_to(3);
    chk("idle_wait_ocupado", 32'(ocupado), 32'd0);
    cyc = 0;
    start4();
    chk("t1_c1_valido", 32'(valido), 32'd1);
    chk("t1_c1_ocupado", 32'(ocupado), 32'd1);
    chk("t1_c1_mdc", 32'(mdc), 32'd0);
    chk("t1_c1_mdl", 32'(mdl), 32'd0);
    chk("t1_c1_linha", 32'(linha_n), 32'hFE);
    tick();
    chk("t1_c2_valido", 32'(valido), 32'd0);
    run_to(5);
    chk("t1_c5_mdc", 32'(mdc), 32'd1);
    chk("t1_c5_mdl", 32'(mdl), 32'd0);
    chk("t1_c5_valido", 32'(valido), 32'd1);
    run_to(21);
    chk("t1_c21_mdc", 32'(mdc), 32'd0);
    chk("t1_c21_mdl", 32'(mdl), 32'd1);
    chk("t1_c21_linha", 32'(linha_n), 32'hFD);
    run_to(140);
    chk("t1_no_early_qfim", 32'(qf_cnt), 32'd0);
    chk("t1_c140_mdc", 32'(mdc), 32'd4);
    chk("t1_c140_mdl", 32'(mdl), 32'd6);
    run_to(141);
    chk("t1_c141_qfim", 32'(quadro_fim), 32'd1);
    chk("t1_c141_ocupado", 32'(ocupado), 32'd0);
    chk("t1_c141_valido", 32'(valido), 32'd0);
    chk("t1_c141_mdc", 32'(mdc), 32'd0);
    chk("t1_c141_mdl", 32'(mdl), 32'd0);
    chk("t1_c141_linha", 32'(linha_n), 32'hFF);
    tick();
    chk("t1_c142_qfim", 32'(quadro_fim), 32'd0);
    run_to(150);
    chk("t1_stays_idle", 32'(ocupado), 32'd0);

    // Continuous mode.
    do_reset();
    continuo = 1'b1;
    start4();
    run_to(141);
    chk("t2_c141_qfim", 32'(quadro_fim), 32'd1);
    chk("t2_c141_valido", 32'(valido), 32'd1);
    chk("t2_c141_ocupado", 32'(ocupado), 32'd1);
    chk("t2_c141_mdc", 32'(mdc), 32'd0);
    chk("t2_c141_mdl", 32'(mdl), 32'd0);
    run_to(280);
    chk("t2_one_qfim_by_280", 32'(qf_cnt), 32'd1);
    run_to(281);
    chk("t2_c281_qfim", 32'(quadro_fim), 32'd1);
    chk("t2_c281_valido", 32'(valido), 32'd1);
    chk("t2_c281_mdl", 32'(mdl), 32'd0);
    continuo = 1'b0;
    run_to(421);
    chk("t2_c421_qfim", 32'(quadro_fim), 32'd1);
    chk("t2_c421_ocupado", 32'(ocupado), 32'd0);

    // Pause for 10 cycles at (4,2), which appears at cycle 57.
    do_reset();
    start4();
    run_to(57);
    chk("t3_c57_mdc", 32'(mdc), 32'd4);
    chk("t3_c57_mdl", 32'(mdl), 32'd2);
    pausa = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_frozen_mdc", 32'(mdc), 32'd4);
      chk("t3_frozen_mdl", 32'(mdl), 32'd2);
      chk("t3_frozen_valido", 32'(valido), 32'd0);
    end
    pausa = 1'b0;
    run_to(70);
    chk("t3_c70_mdc", 32'(mdc), 32'd4);
    run_to(71);
    chk("t3_c71_mdc", 32'(mdc), 32'd0);
    chk("t3_c71_mdl", 32'(mdl), 32'd3);
    chk("t3_c71_valido", 32'(valido), 32'd1);
    run_to(150);
    chk("t3_no_qfim_by_150", 32'(qf_cnt), 32'd0);
    run_to(151);
    chk("t3_c151_qfim", 32'(quadro_fim), 32'd1);
    chk("t3_c151_ocupado", 32'(ocupado), 32'd0);

    // Reset mid-scan at (3,5), which appears at cycle 113.
    do_reset();
    start4();
    run_to(113);
    chk("t4_c113_mdc", 32'(mdc), 32'd3);
    chk("t4_c113_mdl", 32'(mdl), 32'd5);
    chk("t4_c113_linha", 32'(linha_n), 32'hDF);
    reset_n = 1'b0;
    #1;
    chk("t4_async_ocupado", 32'(ocupado), 32'd0);
    tick();
    chk_idle("t4_rst");
    reset_n = 1'b1;
    run_to(cyc + 4);
    chk_idle("t4_after");

    // iniciar during scan at (2,1), which appears at cycle 29.
    do_reset();
    start4();
    run_to(29);
    chk("t5_c29_mdc", 32'(mdc), 32'd2);
    chk("t5_c29_mdl", 32'(mdl), 32'd1);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("t5_c30_mdc", 32'(mdc), 32'd2);
    chk("t5_c30_mdl", 32'(mdl), 32'd1);
    chk("t5_c30_valido", 32'(valido), 32'd0);
    run_to(33);
    chk("t5_c33_mdc", 32'(mdc), 32'd3);
    chk("t5_c33_mdl", 32'(mdl), 32'd1);
    chk("t5_c33_valido", 32'(valido), 32'd1);
    run_to(141);
    chk("t5_c141_qfim", 32'(quadro_fim), 32'd1);

    // DIV=1: one position per cycle.
    do_reset();
    iniciar1 = 1'b1;
    tick();
    iniciar1 = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      if (k > 1) tick();
      chk("t6_valido", 32'(valido1), 32'd1);
      chk("t6_qfim_low", 32'(quadro_fim1), 32'd0);
      chk("t6_mdc", 32'(mdc1), 32'((k - 1) % 5));
      chk("t6_mdl", 32'(mdl1), 32'((k - 1) / 5));
      chk("t6_linha", 32'(linha_n1), 32'(8'hFF ^ (8'd1 << ((k - 1) / 5))));
    end
    tick();
    chk("t6_c36_qfim", 32'(quadro_fim1), 32'd1);
    chk("t6_c36_valido", 32'(valido1), 32'd0);
    chk("t6_c36_ocupado", 32'(ocupado1), 32'd0);
    chk("t6_c36_linha", 32'(linha_n1), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
